// File: rtl/axilite_initiator.sv
// Single-outstanding AXI4-Lite master: converts a local command/response
// handshake into one AXI-Lite read or write at a time, and counts non-OKAY
// responses in a saturating counter.
module axilite_initiator #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [2:0]  PROT         = 3'b000,
  parameter int          ERRCNT_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  // local command side
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // local response side
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ERRCNT_WIDTH-1:0]   err_count,
  // write address channel
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  // write data channel
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  // write response channel
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AD   = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]              state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
  logic                    awvalid_q,   awvalid_d;
  logic                    wvalid_q,    wvalid_d;
  logic                    bready_q,    bready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
  logic                    arvalid_q,   arvalid_d;
  logic                    rready_q,    rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q,  rsp_resp_d;
  logic [ERRCNT_WIDTH-1:0] err_count_q, err_count_d;

  // Response-capture event feeding the error counter
  logic                    cap_vld;
  logic [1:0]              cap_resp;

  // Next-state logic for the transaction FSM, channel registers and error counter
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_count_d = err_count_q;
    cap_vld     = 1'b0;
    cap_resp    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AD;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR_AD: begin
        // AW and W complete independently; a cleared valid marks a done channel
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          cap_vld     = 1'b1;
          cap_resp    = bresp;
          state_d     = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_valid_d = 1'b1;
          cap_vld     = 1'b1;
          cap_resp    = rresp;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        // Returning to IDLE here means cmd_ready rises only next cycle
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any non-OKAY response (EXOKAY included) counts; saturates at all-ones
    if (cap_vld && (cap_resp != 2'b00) && (err_count_q != '1))
      err_count_d = err_count_q + ERRCNT_WIDTH'(1);
  end

  // State and output registers; reset clears every valid/ready asynchronously
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign awaddr    = awaddr_q;
  assign awprot    = PROT;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arprot    = PROT;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_axilite_initiator.sv
// Bench for axilite_initiator: AXI-Lite slave model with configurable ready
// latency and response codes, a transaction-level reference model checked on
// every cycle, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_axilite_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int EMAX = (1 << EW) - 1;

  logic          aclk, areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [EW-1:0] err_count;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  axilite_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000), .ERRCNT_WIDTH(EW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err_count(err_count),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // ---------------- slave model ----------------
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic [1:0]  b_cfg = 2'b00, r_cfg = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        got_aw, got_w;
  logic [31:0] s_addr, s_data, s_wa, s_wd;
  logic [3:0]  s_strb, s_ws;
  logic [31:0] smem [16];

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid  && (w_cnt  >= w_lat);
  assign arready = arvalid && (ar_cnt >= ar_lat);
  assign s_wa    = got_aw ? s_addr : awaddr;
  assign s_wd    = got_w  ? s_data : wdata;
  assign s_ws    = got_w  ? s_strb : wstrb;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      s_addr <= '0; s_data <= '0; s_strb <= '0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
      if (wvalid)  w_cnt  <= wready  ? 0 : w_cnt + 1;
      if (arvalid) ar_cnt <= arready ? 0 : ar_cnt + 1;
      if (awvalid && awready) begin got_aw <= 1'b1; s_addr <= awaddr; end
      if (wvalid && wready) begin got_w <= 1'b1; s_data <= wdata; s_strb <= wstrb; end
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
        smem[s_wa[5:2]] <= merge(smem[s_wa[5:2]], s_wd, s_ws);
        got_aw <= 1'b0; got_w <= 1'b0;
        bvalid <= 1'b1; bresp <= b_cfg;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= smem[araddr[5:2]]; rresp <= r_cfg;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- transaction-level reference model + compare ----------------
  typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t        q[$];
  exp_t        cur;
  bit          cur_v, busy;
  int          exp_err;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic [31:0] ref_mem [16];
  bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;

  initial begin
    cur_v = 0; busy = 0; exp_err = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    c_addr = '0; c_wdata = '0; c_wstrb = '0; cur = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        q.delete(); cur_v = 0; busy = 0; exp_err = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      end else begin
        chk("cmd_ready", 64'(cmd_ready), 64'(!busy));
        chk("prot", 64'({awprot, arprot}), 64'd0);
        if (rsp_valid && !cur_v) begin
          if (q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else begin
            cur = q.pop_front();
            cur_v = 1;
            if (cur.resp != 2'b00 && exp_err < EMAX) exp_err++;
          end
        end
        if (cur_v) begin
          chk("rsp_valid_hold", 64'(rsp_valid), 64'd1);
          chk("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(cur.resp));
        end
        chk("err_count", 64'(err_count), 64'(exp_err));
        if (awvalid) chk("awaddr", 64'(awaddr), 64'(c_addr));
        if (wvalid)  chk("wdata_wstrb", 64'({wdata, wstrb}), 64'({c_wdata, c_wstrb}));
        if (arvalid) chk("araddr", 64'(araddr), 64'(c_addr));
        if (p_awv && !p_awr) chk("awvalid_hold", 64'(awvalid), 64'd1);
        if (p_wv && !p_wr)   chk("wvalid_hold", 64'(wvalid), 64'd1);
        if (p_arv && !p_arr) chk("arvalid_hold", 64'(arvalid), 64'd1);
        p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
        p_arv = arvalid; p_arr = arready;
        if (rsp_valid && rsp_ready) begin cur_v = 0; busy = 0; end
        if (cmd_valid && cmd_ready) begin
          busy = 1;
          c_addr = cmd_addr; c_wdata = cmd_wdata; c_wstrb = cmd_wstrb;
          if (cmd_write) begin
            ref_mem[cmd_addr[5:2]] = merge(ref_mem[cmd_addr[5:2]], cmd_wdata, cmd_wstrb);
            q.push_back('{rdata: 32'd0, resp: b_cfg});
          end else begin
            q.push_back('{rdata: ref_mem[cmd_addr[5:2]], resp: r_cfg});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge aclk);
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode 1: zero-wait latency checks; mode 2: awready delayed 4 cycles
  task automatic collect(input logic w, input int mode, input int hold,
                         output logic [31:0] rd, output logic [1:0] rs, output logic [1:0] ec);
    int k = 0;
    do begin
      @(negedge aclk); k++;
      if (mode == 1 && k == 1) chk("lat_c1_valids", 64'({awvalid, wvalid, arvalid}), w ? 64'd6 : 64'd1);
      if (mode == 1 && k == 2) chk("lat_c2_readies", 64'({bready, rready}), w ? 64'd2 : 64'd1);
      if (mode == 2 && (k == 2 || k == 5)) chk("t3_aw_wait", 64'({awvalid, wvalid, bready}), 64'd4);
      if (mode == 2 && k == 6) chk("t3_after_aw", 64'({awvalid, wvalid, bready}), 64'd1);
    end while (!rsp_valid && k < 200);
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    if (mode == 1) chk("lat_rsp_cycle", 64'(k), 64'd3);
    if (mode == 2) chk("t3_rsp_cycle", 64'(k), 64'd7);
    rd = rsp_rdata; rs = rsp_resp; ec = err_count;
    repeat (hold) @(negedge aclk);
    @(posedge aclk); #1;
    rsp_ready = 1'b1;
    @(negedge aclk);
    chk("cmd_ready_in_rsp_hs", 64'(cmd_ready), 64'd0);
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_after_rsp", 64'({cmd_ready, rsp_valid}), 64'd2);
    @(posedge aclk); #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, ec;
  int          e5 [5] = '{1, 2, 3, 3, 3};

  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ctl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_resp, err_count, wstrb}), 64'd0);
    chk("rst_addr", 64'({awaddr, araddr}), 64'd0);
    chk("rst_data", 64'({wdata, rsp_rdata}), 64'd0);
    @(negedge aclk); #2 areset = 1'b0;
    @(posedge aclk); #1;

    // 1: zero-wait write
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    collect(1'b1, 1, 0, rd, rs, ec);
    chk("t1_rsp", 64'({rd, rs, ec}), 64'h0);

    // 2: read back
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    collect(1'b0, 1, 0, rd, rs, ec);
    chk("t2_rsp", 64'({rd, rs, ec}), {28'd0, 32'hDEADBEEF, 4'h0});

    // 3: awready delayed, partial strobes
    aw_lat = 4;
    issue(1'b1, 32'h20, 32'h12345678, 4'h5);
    collect(1'b1, 2, 0, rd, rs, ec);
    chk("t3_rsp", 64'({rd, rs}), 64'h0);
    aw_lat = 0;

    // 4: read with rsp_ready held low
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    collect(1'b0, 0, 5, rd, rs, ec);
    chk("t4_rsp", 64'({rd, rs}), {30'd0, 32'h00340078, 2'b00});

    // 5: SLVERR reads, saturating counter
    r_cfg = 2'b10;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 32'h14, 32'h0, 4'h0);
      collect(1'b0, 0, 0, rd, rs, ec);
      chk("t5_resp", 64'(rs), 64'd2);
      chk("t5_err_count", 64'(ec), 64'(e5[i]));
    end
    r_cfg = 2'b00;

    // 6: asynchronous reset during the write address phase
    aw_lat = 50;
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    @(negedge aclk);
    chk("t6_pre_awvalid", 64'(awvalid), 64'd1);
    #2 areset = 1'b1;
    #1;
    chk("t6_async_drop", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    chk("t6_cmd_ready_in_rst", 64'(cmd_ready), 64'd1);
    repeat (2) @(negedge aclk);
    #2 areset = 1'b0;
    aw_lat = 0;
    @(posedge aclk); #1;
    chk("t6_post_rst", 64'({cmd_ready, err_count}), 64'd4);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    collect(1'b0, 1, 0, rd, rs, ec);
    chk("t6_read", 64'({rd, rs, ec}), {28'd0, 32'hDEADBEEF, 4'h0});

    repeat (2) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
